// File: rtl/i2s_tx.sv
// I2S transmitter: one stereo pair per frame, MSB-first, timed by bck.
// Define I2S_TX_HOLD_EN to repeat the last pair on underrun instead of silence.
module i2s_tx #(
  parameter int WIDTH = 16,
  parameter int SLOT  = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bck,
  input  logic [WIDTH-1:0] sample_l,
  input  logic [WIDTH-1:0] sample_r,
  input  logic             sample_valid,
  output logic             sample_ready,
  output logic             lrck,
  output logic             sdata,
  output logic             underrun
);

  localparam int CW = $clog2(2 * SLOT);
  localparam logic [CW-1:0] LAST   = CW'(2 * SLOT - 1);
  localparam logic [CW-1:0] SLOT_C = CW'(SLOT);
  localparam logic [CW-1:0] W_C    = CW'(WIDTH);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic             bck_q;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             full_q, full_d;
  logic [WIDTH-1:0] stg_l_q, stg_l_d;
  logic [WIDTH-1:0] stg_r_q, stg_r_d;
  logic [WIDTH-1:0] sh_l_q, sh_l_d;
  logic [WIDTH-1:0] sh_r_q, sh_r_d;
  logic             lrck_q, lrck_d;
  logic             sdata_q, sdata_d;
  logic             und_q, und_d;

  logic             fall;
  logic             accept;
  logic             wrap;
  logic [CW-1:0]    k;
  logic [CW-1:0]    idx;
  logic [WIDTH-1:0] sel;
  logic [WIDTH-1:0] mask;

  always_comb begin
    fall    = bck_q & ~bck;
    accept  = sample_valid & ~full_q;
    wrap    = fall & (cnt_q == LAST);
    cnt_d   = cnt_q;
    full_d  = full_q;
    stg_l_d = stg_l_q;
    stg_r_d = stg_r_q;
    sh_l_d  = sh_l_q;
    sh_r_d  = sh_r_q;
    lrck_d  = lrck_q;
    sdata_d = sdata_q;
    und_d   = 1'b0;
    k       = '0;
    idx     = '0;
    sel     = '0;
    mask    = '0;

    if (accept) begin
      full_d  = 1'b1;
      stg_l_d = sample_l;
      stg_r_d = sample_r;
    end

    // accept needs ~full_q, a loading wrap needs full_q: never both
    if (wrap) begin
      if (full_q) begin
        sh_l_d = stg_l_q;
        sh_r_d = stg_r_q;
        full_d = 1'b0;
      end else begin
`ifdef I2S_TX_HOLD_EN
        sh_l_d = sh_l_q;
        sh_r_d = sh_r_q;
`else
        sh_l_d = '0;
        sh_r_d = '0;
`endif
        und_d = 1'b1;
      end
    end

    if (fall) begin
      cnt_d   = wrap ? '0 : cnt_q + 1'b1;
      lrck_d  = (cnt_d >= SLOT_C);
      k       = lrck_d ? cnt_d - SLOT_C : cnt_d;
      sel     = lrck_d ? sh_r_d : sh_l_d;
      idx     = W_C - k;
      mask    = ONE << idx;
      sdata_d = (k != '0) && (k <= W_C) && (|(sel & mask));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bck_q   <= 1'b0;
      cnt_q   <= LAST;
      full_q  <= 1'b0;
      stg_l_q <= '0;
      stg_r_q <= '0;
      sh_l_q  <= '0;
      sh_r_q  <= '0;
      lrck_q  <= 1'b1;
      sdata_q <= 1'b0;
      und_q   <= 1'b0;
    end else begin
      bck_q   <= bck;
      cnt_q   <= cnt_d;
      full_q  <= full_d;
      stg_l_q <= stg_l_d;
      stg_r_q <= stg_r_d;
      sh_l_q  <= sh_l_d;
      sh_r_q  <= sh_r_d;
      lrck_q  <= lrck_d;
      sdata_q <= sdata_d;
      und_q   <= und_d;
    end
  end

  assign sample_ready = ~full_q;
  assign lrck         = lrck_q;
  assign sdata        = sdata_q;
  assign underrun     = und_q;

endmodule
